// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } ifu_state_e;

    localparam int unsigned PC_INC = 4;

    function automatic int unsigned ifu_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned ifu_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous instruction buffer with registered head/valid outputs and a clear input.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = ifu_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = ifu_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;

    // Next head is read from the post-write storage so a push into an empty buffer shows next cycle
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != '0);
        head_d  = clear_i ? '0 : mem_d[rptr_d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign valid_o = valid_q;
    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding memory read FSM and instruction buffer toward decode.
// Defining IFU_PERF_CNT_EN adds perf_fetched / perf_stall counter outputs.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rsp_valid,
    input  logic [INSTR_W-1:0]  mem_rsp_data,
    input  logic                redir_valid,
    input  logic [ADDR_W-1:0]   redir_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);

    localparam int unsigned CNT_W = ifu_cnt_w(FIFO_DEPTH);

    ifu_state_e           state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    req_pc_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 req_valid_q;

    logic                 push;
    logic                 pop;
    logic                 fifo_valid;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     count_after;
    logic                 slot_free_after;
    logic [ADDR_W-1:0]    redir_target;
    logic [INSTR_W+ADDR_W-1:0] fifo_head;
    logic                 redir_lsb_unused;

    // Redirect outranks both the memory response and the decode pop
    assign push            = (state_q == WAIT) && mem_rsp_valid && !redir_valid;
    assign pop             = fifo_valid && instr_ready && !redir_valid;
    assign count_after     = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign slot_free_after = (count_after < CNT_W'(FIFO_DEPTH));
    assign redir_target    = {redir_pc[ADDR_W-1:2], 2'b00};
    assign redir_lsb_unused = ^redir_pc[1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            mem_addr_q  <= RESET_PC;
            req_valid_q <= 1'b0;
        end else if (redir_valid) begin
            pc_q        <= redir_target;
            req_valid_q <= 1'b0;
            case (state_q)
                REQ:         state_q <= mem_req_ready ? FLUSH : IDLE;
                WAIT, FLUSH: state_q <= mem_rsp_valid ? IDLE : FLUSH;
                default:     state_q <= IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                        mem_addr_q  <= pc_q;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                        req_pc_q    <= mem_addr_q;
                        pc_q        <= pc_q + ADDR_W'(PC_INC);
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (slot_free_after) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                            mem_addr_q  <= pc_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_rsp_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clear_i (redir_valid),
        .push_i  (push),
        .wdata_i ({mem_rsp_data, req_pc_q}),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign mem_req_valid     = req_valid_q;
    assign mem_addr          = mem_addr_q;
    assign instr_valid       = fifo_valid;
    assign {instr, instr_pc} = fifo_head;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Counters survive redirects; only reset clears them
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (fifo_valid && !instr_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
